// File: rtl/quartet_loader_pkg.sv
// Shared TIA constants plus the loader state encoding and MMIO index helper.
package quartet_loader_pkg;

    localparam int TIA_MMIO_DATA_WIDTH                           = 32;
    localparam int TIA_MMIO_INDEX_WIDTH                          = 16;
    localparam int TIA_NUM_REGISTER_FILE_WORDS                   = 4;
    localparam int TIA_NUM_INSTRUCTION_MEMORY_WORDS              = 4;
    localparam int TIA_ROUTER_SETTING_MEMORY_WORDS               = 2;
    localparam int TIA_NUM_PROCESSING_ELEMENT_ADDRESS_SPACE_WORDS = 64;
    localparam int TIA_CORE_REGISTER_FILE_BASE_INDEX             = 8;
    localparam int TIA_ROUTER_BASE_INDEX                         = 48;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_FETCH,
        LS_WRITE,
        LS_RELEASE,
        LS_RUN,
        LS_DONE,
        LS_ERROR
    } quartet_loader_state_t;

    // PE window offset plus in-window word, truncated to the MMIO index width.
    function automatic logic [TIA_MMIO_INDEX_WIDTH-1:0] mmio_index(
        input logic [31:0] pe,
        input logic [31:0] base,
        input logic [31:0] word
    );
        logic [31:0] full;
        full = pe * 32'(TIA_NUM_PROCESSING_ELEMENT_ADDRESS_SPACE_WORDS) + base + word;
        return full[TIA_MMIO_INDEX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/mmio_if.sv
// Host MMIO port of the quartet: independent read and write req/ack channels.
interface mmio_if;
    import quartet_loader_pkg::*;

    logic                            read_req;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] read_index;
    logic                            read_ack;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  read_data;
    logic                            write_req;
    logic [TIA_MMIO_INDEX_WIDTH-1:0] write_index;
    logic [TIA_MMIO_DATA_WIDTH-1:0]  write_data;
    logic                            write_ack;

    modport requester (
        output read_req, read_index, write_req, write_index, write_data,
        input  read_ack, read_data, write_ack
    );

    modport responder (
        input  read_req, read_index, write_req, write_index, write_data,
        output read_ack, read_data, write_ack
    );

endinterface

// File: rtl/quartet_loader.sv
// Boot sequencer: streams an external image ROM into the quartet over MMIO,
// then runs the array until it halts.
module quartet_loader
    import quartet_loader_pkg::*;
#(
    parameter int  NUM_PES      = 4,
    parameter bit  LOAD_ROUTERS = 1'b1,
    parameter int  ACK_TIMEOUT  = 1024,
    localparam int P     = TIA_NUM_REGISTER_FILE_WORDS + TIA_NUM_INSTRUCTION_MEMORY_WORDS,
    localparam int R     = TIA_ROUTER_SETTING_MEMORY_WORDS,
    localparam int IMG_W = $clog2(NUM_PES * (P + R))
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           start,
    output logic [IMG_W-1:0]               image_read_index,
    input  logic [TIA_MMIO_DATA_WIDTH-1:0] image_read_data,
    mmio_if.requester                      host_interface,
    output logic                           execute,
    input  logic                           halted,
    output logic                           busy,
    output logic                           done,
    output logic                           error
);

    localparam int WORD_MAX = (P > R) ? P : R;
    localparam int PE_W     = (NUM_PES > 1) ? $clog2(NUM_PES) : 1;
    localparam int J_W      = (WORD_MAX > 1) ? $clog2(WORD_MAX) : 1;
    localparam int WAIT_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [PE_W-1:0]   PE_LAST   = PE_W'(NUM_PES - 1);
    localparam logic [J_W-1:0]    P_LAST    = J_W'(P - 1);
    localparam logic [J_W-1:0]    R_LAST    = J_W'(R - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

    quartet_loader_state_t state_q, state_d;
    logic [IMG_W-1:0]      k_q, k_d;
    logic [PE_W-1:0]       i_q, i_d;
    logic [J_W-1:0]        j_q, j_d;
    logic                  router_q, router_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  last_word;
    logic                  wait_expired;

    // NOTE: reset is checked before enable so a frozen loader can still be cleared;
    // state registers use non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= LS_IDLE;
            k_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            router_q <= 1'b0;
            wait_q   <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else if (enable) begin
            state_q  <= state_d;
            k_q      <= k_d;
            i_q      <= i_d;
            j_q      <= j_d;
            router_q <= router_d;
            wait_q   <= wait_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign last_word = (i_q == PE_LAST) &&
                       (router_q ? (j_q == R_LAST) : (!LOAD_ROUTERS && j_q == P_LAST));
    assign wait_expired = (wait_q == WAIT_LAST);

    // NOTE: every always_comb target gets its hold value first, so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        i_d      = i_q;
        j_d      = j_q;
        router_d = router_q;
        wait_d   = wait_q;
        done_d   = done_q;
        error_d  = error_q;

        unique case (state_q)
            LS_IDLE, LS_DONE, LS_ERROR: begin
                if (start) begin
                    state_d  = LS_FETCH;
                    k_d      = '0;
                    i_d      = '0;
                    j_d      = '0;
                    router_d = 1'b0;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                end
            end
            LS_FETCH: begin
                state_d = LS_WRITE;
                wait_d  = '0;
            end
            LS_WRITE: begin
                if (host_interface.write_ack) begin
                    state_d = LS_RELEASE;
                    wait_d  = '0;
                end else if (wait_expired) begin
                    state_d = LS_ERROR;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            LS_RELEASE: begin
                if (!host_interface.write_ack) begin
                    k_d     = k_q + IMG_W'(1);
                    state_d = last_word ? LS_RUN : LS_FETCH;
                    // Program phase finishing its last PE hands over to the router phase.
                    if (j_q == (router_q ? R_LAST : P_LAST)) begin
                        j_d = '0;
                        if (i_q == PE_LAST) begin
                            i_d      = '0;
                            router_d = LOAD_ROUTERS;
                        end else begin
                            i_d = i_q + PE_W'(1);
                        end
                    end else begin
                        j_d = j_q + J_W'(1);
                    end
                end else if (wait_expired) begin
                    state_d = LS_ERROR;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            LS_RUN: begin
                if (halted) begin
                    state_d = LS_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = LS_IDLE;
        endcase
    end

    always_comb begin
        host_interface.read_req    = 1'b0;
        host_interface.read_index  = '0;
        host_interface.write_req   = (state_q == LS_WRITE);
        host_interface.write_index = '0;
        host_interface.write_data  = '0;
        if (state_q == LS_WRITE) begin
            host_interface.write_index = mmio_index(
                32'(i_q),
                router_q ? 32'(TIA_ROUTER_BASE_INDEX) : 32'(TIA_CORE_REGISTER_FILE_BASE_INDEX),
                32'(j_q));
            host_interface.write_data  = image_read_data;
        end
    end

    // ROM index stays on k so the synchronous ROM output is stable through WRITE.
    assign image_read_index = k_q;
    assign execute          = (state_q == LS_RUN);
    assign busy             = !(state_q inside {LS_IDLE, LS_DONE, LS_ERROR});
    assign done             = done_q;
    assign error            = error_q;

endmodule
